// File: rtl/wordle_pkg.sv
// Shared Wordle constants: word geometry, colour codes and the scorer's
// state encoding. Imported by the scorer, its match helper and the guess SM.
package wordle_pkg;

  localparam int N      = 5;   // letters per word
  localparam int CHAR_W = 8;   // bits per ASCII character

  localparam logic [1:0] GREY   = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // state     | meaning
  // S_IDLE    | waiting for Start
  // S_GREEN   | exact-position matches, all letters at once
  // S_YELLOW  | one guess position per cycle, left to right
  // S_DONE    | Done pulse, final score/Win visible
  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_DONE
  } scorer_state_t;

endpackage

// File: rtl/wordle_scorer_if.sv
// Request/result bundle for wordle_scorer.
//   Start  : single-cycle request, samples guess/answer when accepted
//   guess  : guess word, position 0 in the top CHAR_W bits
//   answer : word of the day, same packing
//   Busy   : job in flight
//   Done   : one-cycle pulse, score/Win valid
//   score  : 2 bits per position, position 0 in the top two bits
//   Win    : all positions green
interface wordle_scorer_if;

  logic                                       Start;
  logic [wordle_pkg::N*wordle_pkg::CHAR_W-1:0] guess;
  logic [wordle_pkg::N*wordle_pkg::CHAR_W-1:0] answer;
  logic                                       Busy;
  logic                                       Done;
  logic [2*wordle_pkg::N-1:0]                 score;
  logic                                       Win;

  modport master (output Start, guess, answer, input Busy, Done, score, Win);
  modport slave  (input Start, guess, answer, output Busy, Done, score, Win);

endinterface

// File: rtl/wordle_first_match.sv
// Finds the lowest answer position that holds i_letter and has not yet been
// consumed. Purely combinational.
//   i_letter : letter being searched for
//   i_answer : answer word, position 0 in the top CHAR_W bits
//   i_used   : consumed mask, bit j = answer position j
//   o_found  : some unconsumed position matches
//   o_idx    : one-hot of the lowest matching position (bit j = position j)
module wordle_first_match
  import wordle_pkg::*;
(
  input  logic [CHAR_W-1:0]   i_letter,
  input  logic [N*CHAR_W-1:0] i_answer,
  input  logic [N-1:0]        i_used,
  output logic                o_found,
  output logic [N-1:0]        o_idx
);

  logic [N-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int j = 0; j < N; j++) begin
      w_hit[j] = !i_used[j] && (i_answer[N*CHAR_W-1-j*CHAR_W -: CHAR_W] == i_letter);
    end
  end

  // Position 0 sits in bit 0, so isolating the lowest set bit picks the
  // leftmost eligible answer letter.
  assign o_idx   = w_hit & (~w_hit + N'(1));
  assign o_found = |w_hit;

endmodule

// File: rtl/wordle_scorer.sv
// Scores a 5-letter guess against the word of the day. Greens are resolved in
// one cycle, then yellows one guess position per cycle so that each answer
// letter is consumed at most once, leftmost guess letter first.
//   Clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : request/result bundle (slave side)
module wordle_scorer
  import wordle_pkg::*;
(
  input  logic           Clk,
  input  logic           reset,
  wordle_scorer_if.slave bus
);

  localparam int                 CNT_W     = $clog2(N);
  localparam logic [CNT_W-1:0]   LAST_POS  = CNT_W'(N-1);
  localparam logic [2*N-1:0]     ALL_GREEN = {N{GREEN}};

  scorer_state_t       r_state, w_state_nxt;
  logic [N*CHAR_W-1:0] r_guess, r_answer;
  logic [2*N-1:0]      r_score, w_score_nxt;
  logic [N-1:0]        r_used, w_used_nxt;
  logic                r_win, w_win_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                w_load;
  logic [CNT_W-1:0]    w_pos;
  logic [CHAR_W-1:0]   w_letter;
  logic                w_found;
  logic [N-1:0]        w_idx;

  // Yellow pass counts down; the position handled ascends from 0.
  assign w_pos = LAST_POS - r_cnt;

  always_comb begin
    w_letter = '0;
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) == w_pos) w_letter = r_guess[N*CHAR_W-1-i*CHAR_W -: CHAR_W];
    end
  end

  wordle_first_match u_first_match (
    .i_letter (w_letter),
    .i_answer (r_answer),
    .i_used   (r_used),
    .o_found  (w_found),
    .o_idx    (w_idx)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_used_nxt  = r_used;
    w_win_nxt   = r_win;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_load      = 1'b1;
          w_score_nxt = '0;
          w_used_nxt  = '0;
          w_win_nxt   = 1'b0;
          w_state_nxt = S_GREEN;
        end
      end
      S_GREEN: begin
        for (int i = 0; i < N; i++) begin
          if (r_guess[N*CHAR_W-1-i*CHAR_W -: CHAR_W] == r_answer[N*CHAR_W-1-i*CHAR_W -: CHAR_W]) begin
            w_score_nxt[2*N-1-2*i -: 2] = GREEN;
            w_used_nxt[i]               = 1'b1;
          end else begin
            w_score_nxt[2*N-1-2*i -: 2] = GREY;
          end
        end
        w_cnt_nxt   = LAST_POS;
        w_state_nxt = S_YELLOW;
      end
      S_YELLOW: begin
        for (int i = 0; i < N; i++) begin
          if (CNT_W'(i) == w_pos && r_score[2*N-1-2*i -: 2] != GREEN && w_found) begin
            w_score_nxt[2*N-1-2*i -: 2] = YELLOW;
            w_used_nxt                  = r_used | w_idx;
          end
        end
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          w_win_nxt   = (w_score_nxt == ALL_GREEN);
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_guess  <= '0;
      r_answer <= '0;
      r_score  <= '0;
      r_used   <= '0;
      r_win    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_load) begin
        r_guess  <= bus.guess;
        r_answer <= bus.answer;
      end
      r_score <= w_score_nxt;
      r_used  <= w_used_nxt;
      r_win   <= w_win_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.Busy  = (r_state != S_IDLE);
  assign bus.Done  = (r_state == S_DONE);
  assign bus.score = r_score;
  assign bus.Win   = r_win;

endmodule
